// File: rtl/axi2apb_bridge_if.sv
// axi_intf: AXI3-style bus bundle between an upstream AXI master and the
// axi2apb_bridge slave port.
//   master modport : drives AW/W/AR requests, bready and rready
//   slave  modport : drives awready/wready/arready plus the B and R responses
// wid, wlast, awlock and arlock are carried for completeness; the bridge
// ignores them.
interface axi_intf #(
  parameter int ID_WIDTH   = 10,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // write address
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  // write data
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // write response
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // read address
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  // read data
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi2apb_bridge.sv
// axi2apb_bridge: converts AXI bursts into sequences of APB transfers, one
// AXI transaction outstanding at a time.
// Ports:
//   clk, rstn      - single clock, asynchronous active-low reset
//   s_axi          - AXI slave port (axi_intf.slave)
//   psel, penable, pwrite, paddr, pwdata, pstrb, pprot - APB requester outputs
//   prdata, pready, pslverr                            - APB completer inputs
// Optional feature: define AXI2APB_TIMEOUT_EN to end an APB access that has
// waited 256 ACCESS cycles without pready, reporting SLVERR with zero data.
module axi2apb_bridge #(
  parameter int ID_WIDTH   = 10,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  axi_intf.slave                  s_axi,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RDATA  = 3'd4,
    BRESP  = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_rd_q;   // previous grant went to the read channel
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;       // beats already completed
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [2:0]              prot_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    err_q;       // sticky slave error over a write burst
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;

  logic grant_rd, grant_wr;
  logic aw_hs, ar_hs, w_acc, r_out, b_out, sel_c, en_c;
  logic last_beat, beat_done, beat_err;
  logic [DATA_WIDTH-1:0] beat_rdata;

  // wid, wlast and the lock bits carry no meaning for this bridge.
  logic unused_axi;
  assign unused_axi = ^{s_axi.wid, s_axi.wlast, s_axi.awlock, s_axi.arlock};

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [1:0]            burst,
    input logic [2:0]            size
  );
    if (burst == 2'b00) return a;               // FIXED
    return a + (ADDR_WIDTH'(1) << size);        // INCR / WRAP, wraps mod 2^N
  endfunction

  // Round robin: read wins a tie unless the read channel won last time.
  assign grant_rd  = s_axi.arvalid && (!s_axi.awvalid || !last_rd_q);
  assign grant_wr  = s_axi.awvalid && !grant_rd;
  assign last_beat = (cnt_q == len_q);

`ifdef AXI2APB_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  logic       to_expired;

  // to_cnt_q counts ACCESS cycles without pready; the 256th one expires.
  assign to_expired = (state_q == ACCESS) && !pready && (to_cnt_q == 8'hFF);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              to_cnt_q <= '0;
    else if (state_q == ACCESS && !pready)  to_cnt_q <= to_cnt_q + 8'd1;
    else                                    to_cnt_q <= '0;
  end

  assign beat_done = pready || to_expired;
`else
  assign beat_done = pready;
`endif

  // Only consulted when beat_done; without pready it can only be a timeout.
  assign beat_err   = pslverr || !pready;
  assign beat_rdata = pready ? prdata : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    aw_hs   = 1'b0;
    ar_hs   = 1'b0;
    w_acc   = 1'b0;
    r_out   = 1'b0;
    b_out   = 1'b0;
    sel_c   = 1'b0;
    en_c    = 1'b0;
    case (state_q)
      IDLE: begin
        // rstn gate keeps the readys low while reset is held
        if (rstn && grant_rd) begin
          ar_hs   = 1'b1;
          state_d = SETUP;
        end else if (rstn && grant_wr) begin
          aw_hs   = 1'b1;
          state_d = WDATA;
        end
      end
      WDATA: begin
        w_acc = 1'b1;
        if (s_axi.wvalid) state_d = SETUP;
      end
      SETUP: begin
        sel_c   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        sel_c = 1'b1;
        en_c  = 1'b1;
        if (beat_done) begin
          if (!write_q)       state_d = RDATA;
          else if (last_beat) state_d = BRESP;
          else                state_d = WDATA;
        end
      end
      RDATA: begin
        r_out = 1'b1;
        if (s_axi.rready) state_d = last_beat ? IDLE : SETUP;
      end
      BRESP: begin
        b_out = 1'b1;
        if (s_axi.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_rd_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      prot_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      if (ar_hs) begin
        last_rd_q <= 1'b1;
        id_q      <= s_axi.arid;
        addr_q    <= s_axi.araddr;
        len_q     <= s_axi.arlen;
        size_q    <= s_axi.arsize;
        burst_q   <= s_axi.arburst;
        prot_q    <= s_axi.arprot;
        write_q   <= 1'b0;
        cnt_q     <= '0;
      end
      if (aw_hs) begin
        last_rd_q <= 1'b0;
        id_q      <= s_axi.awid;
        addr_q    <= s_axi.awaddr;
        len_q     <= s_axi.awlen;
        size_q    <= s_axi.awsize;
        burst_q   <= s_axi.awburst;
        prot_q    <= s_axi.awprot;
        write_q   <= 1'b1;
        cnt_q     <= '0;
        err_q     <= 1'b0;
      end
      if (w_acc && s_axi.wvalid) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (en_c && beat_done) begin
        if (write_q) begin
          err_q <= err_q | beat_err;
          if (!last_beat) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_addr(addr_q, burst_q, size_q);
          end
        end else begin
          rdata_q <= beat_rdata;
          rresp_q <= beat_err ? 2'b10 : 2'b00;
        end
      end
      if (r_out && s_axi.rready && !last_beat) begin
        cnt_q  <= cnt_q + 8'd1;
        addr_q <= next_addr(addr_q, burst_q, size_q);
      end
    end
  end

  assign s_axi.awready = aw_hs;
  assign s_axi.arready = ar_hs;
  assign s_axi.wready  = w_acc;
  assign s_axi.rvalid  = r_out;
  assign s_axi.rlast   = r_out && last_beat;
  assign s_axi.rid     = id_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.bvalid  = b_out;
  assign s_axi.bid     = id_q;
  assign s_axi.bresp   = err_q ? 2'b10 : 2'b00;

  assign psel    = sel_c;
  assign penable = en_c;
  assign pwrite  = write_q;
  assign paddr   = addr_q;
  assign pwdata  = wdata_q;
  assign pstrb   = write_q ? wstrb_q : '0;
  assign pprot   = prot_q;

endmodule
